// File: rtl/hps_rst_seq_pkg.sv
// Shared types and constants for the HPS reset sequencer.
package hps_rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_WAIT_H2F = 2'd2,
    ST_HOLDOFF  = 2'd3
  } state_e;

  // Encoding is visible on last_src, so the values are fixed.
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_COLD  = 2'd1,
    SRC_WARM  = 2'd2,
    SRC_DEBUG = 2'd3
  } src_e;

  localparam int unsigned REQ_COLD  = 0;
  localparam int unsigned REQ_WARM  = 1;
  localparam int unsigned REQ_DEBUG = 2;

  localparam int unsigned CNT_W_DEF = 26;

  // Fixed priority: cold > warm > debug.
  function automatic src_e pick_src(input logic [2:0] req);
    if (req[REQ_COLD])       return SRC_COLD;
    else if (req[REQ_WARM])  return SRC_WARM;
    else if (req[REQ_DEBUG]) return SRC_DEBUG;
    else                     return SRC_NONE;
  endfunction

  // Request bit belonging to a source.
  function automatic logic [2:0] src_mask(input src_e s);
    case (s)
      SRC_COLD:  return 3'b001;
      SRC_WARM:  return 3'b010;
      SRC_DEBUG: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/hps_reset_sequencer_if.sv
// Request/reset-line bundle between the request sources, the sequencer
// and the HPS f2h/h2f reset pins.
interface hps_reset_sequencer_if;
  logic [2:0] reset_req;          // [0]cold [1]warm [2]debug, request levels
  logic       h2f_reset_n;        // from HPS, asynchronous to clk
  logic       cold_reset_req_n;
  logic       warm_reset_req_n;
  logic       debug_reset_req_n;
  logic       busy;
  logic [1:0] last_src;
  logic       ack_timeout;

  // Request side / HPS model.
  modport master (
    output reset_req, h2f_reset_n,
    input  cold_reset_req_n, warm_reset_req_n, debug_reset_req_n,
           busy, last_src, ack_timeout
  );

  // Sequencer side.
  modport slave (
    input  reset_req, h2f_reset_n,
    output cold_reset_req_n, warm_reset_req_n, debug_reset_req_n,
           busy, last_src, ack_timeout
  );
endinterface

// File: rtl/hps_rst_seq_sync.sv
// Generic 2-FF level synchronizer with a configurable reset value.
module hps_rst_seq_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Two-stage shift into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {2{RST_VAL}};
    else     sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/hps_reset_sequencer.sv
// HPS reset sequencer: converts request-level rising edges into f2h
// cold/warm/debug reset pulses, one at a time by priority, then waits for
// the h2f_reset_n handshake (cold/warm) and a holdoff before accepting more.
// Optional feature macro: HPS_RST_SEQ_PENDING_EN (remember unserved edges).
module hps_reset_sequencer
  import hps_rst_seq_pkg::*;
#(
  parameter int unsigned COLD_PULSE  = 6,
  parameter int unsigned WARM_PULSE  = 2,
  parameter int unsigned DEBUG_PULSE = 32,
  parameter int unsigned HOLDOFF     = 1024,
  parameter int unsigned ACK_TIMEOUT = 50000000,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  hps_reset_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LD_COLD  = CNT_W'(COLD_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_WARM  = CNT_W'(WARM_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_DEBUG = CNT_W'(DEBUG_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] LD_ACK   = CNT_W'(ACK_TIMEOUT - 1);

  logic [2:0]       req_q;
  logic [2:0]       rise;
  logic [2:0]       cand;
  src_e             start_src;
  logic             h2f_s;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             seen_low_q;
  src_e             last_src_q;
  logic             cold_n_q;
  logic             warm_n_q;
  logic             debug_n_q;
  logic             busy_q;
  logic             ack_timeout_q;

  function automatic logic [CNT_W-1:0] pulse_load(input src_e s);
    case (s)
      SRC_COLD: return LD_COLD;
      SRC_WARM: return LD_WARM;
      default:  return LD_DEBUG;
    endcase
  endfunction

  hps_rst_seq_sync #(
    .RST_VAL (1'b1)
  ) u_h2f_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.h2f_reset_n),
    .q_o (h2f_s)
  );

  // Previous request levels; loaded during rst too so a level held through
  // reset produces no edge afterwards.
  always_ff @(posedge clk) begin
    req_q <= bus.reset_req;
  end

  assign rise = bus.reset_req & ~req_q;

`ifdef HPS_RST_SEQ_PENDING_EN
  logic [2:0] pending_q;

  // Arbitrate fresh edges together with remembered ones.
  always_comb begin
    cand      = rise | pending_q;
    start_src = pick_src(cand);
  end

  // Remember every edge not started; a cold start supersedes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start_src == SRC_COLD) pending_q <= '0;
      else                       pending_q <= cand & ~src_mask(start_src);
    end else begin
      pending_q <= pending_q | rise;
    end
  end
`else
  // Only fresh edges are arbitrated; losers are discarded.
  always_comb begin
    cand      = rise;
    start_src = pick_src(cand);
  end
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      seen_low_q    <= 1'b0;
      last_src_q    <= SRC_NONE;
      cold_n_q      <= 1'b1;
      warm_n_q      <= 1'b1;
      debug_n_q     <= 1'b1;
      busy_q        <= 1'b0;
      ack_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_src != SRC_NONE) begin
            state_q    <= ST_PULSE;
            busy_q     <= 1'b1;
            last_src_q <= start_src;
            cnt_q      <= pulse_load(start_src);
            cold_n_q   <= (start_src != SRC_COLD);
            warm_n_q   <= (start_src != SRC_WARM);
            debug_n_q  <= (start_src != SRC_DEBUG);
          end
        end

        ST_PULSE: begin
          if (cnt_q == '0) begin
            cold_n_q  <= 1'b1;
            warm_n_q  <= 1'b1;
            debug_n_q <= 1'b1;
            if (last_src_q == SRC_DEBUG) begin
              state_q <= ST_HOLDOFF;
              cnt_q   <= LD_HOLD;
            end else begin
              state_q    <= ST_WAIT_H2F;
              cnt_q      <= LD_ACK;
              seen_low_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_WAIT_H2F: begin
          if (seen_low_q && h2f_s) begin
            state_q <= ST_HOLDOFF;
            cnt_q   <= LD_HOLD;
          end else if (cnt_q == '0) begin
            ack_timeout_q <= 1'b1;
            state_q       <= ST_HOLDOFF;
            cnt_q         <= LD_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (!h2f_s) seen_low_q <= 1'b1;
          end
        end

        ST_HOLDOFF: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cold_reset_req_n  = cold_n_q;
  assign bus.warm_reset_req_n  = warm_n_q;
  assign bus.debug_reset_req_n = debug_n_q;
  assign bus.busy              = busy_q;
  assign bus.last_src          = last_src_q;
  assign bus.ack_timeout       = ack_timeout_q;

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Bench for hps_reset_sequencer: timeline-based reference model compared
// every cycle, directed scenarios with literal expectations, random phase.
module tb_hps_reset_sequencer;
  import hps_rst_seq_pkg::*;

  localparam int P_COLD = 6;
  localparam int P_WARM = 2;
  localparam int P_DBG  = 32;
  localparam int P_HOLD = 20;
  localparam int P_ACK  = 100;
  localparam int NREC   = 16384;
  localparam int INF    = 32'h3fffffff;
`ifdef HPS_RST_SEQ_PENDING_EN
  localparam int PEND = 1;
`else
  localparam int PEND = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  hps_reset_sequencer_if bus ();

  hps_reset_sequencer #(
    .COLD_PULSE  (P_COLD),
    .WARM_PULSE  (P_WARM),
    .DEBUG_PULSE (P_DBG),
    .HOLDOFF     (P_HOLD),
    .ACK_TIMEOUT (P_ACK),
    .CNT_W       (26)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Cycle c = number of posedges seen; inputs of cycle c are set at the
  // preceding negedge and sampled at the posedge that ends cycle c.
  int         cyc = 0;
  logic [2:0] req_h [NREC];
  logic       h_h   [NREC];
  logic       rst_h [NREC];
  // [7:0] DUT: {0,tmo,busy,src[1:0],dbg_n,warm_n,cold_n}; [15:8] model, same layout
  logic [15:0] rec  [NREC];

  // Reference timeline: a sequence is described by absolute cycle numbers.
  int         m_src   = 0;
  int         m_last  = 0;
  int         m_start = -100;
  int         m_plen  = 0;
  int         m_wait  = 0;
  int         m_seen  = -1;
  int         m_idle  = 0;
  bit         m_tmo   = 1'b0;
  bit         m_valid = 1'b0;
  logic [2:0] m_pend  = 3'b000;
  logic       e_cold, e_warm, e_dbg, e_busy, e_tmo;
  logic [1:0] e_src;

  // Synchronized h2f as seen by the sequencer during cycle k.
  function automatic bit hs(input int k);
    if (k < 2) return 1'b1;
    if (rst_h[k-1] || rst_h[k-2]) return 1'b1;
    return h_h[k-2];
  endfunction

  always @(posedge clk) begin : model
    int         c, n, pick;
    logic [2:0] rise, cand;
    bit         inp;
    c = cyc;
    if (c < NREC) begin
      req_h[c] = bus.reset_req;
      h_h[c]   = bus.h2f_reset_n;
      rst_h[c] = rst;
      if (rst) begin
        m_src = 0; m_last = 0; m_idle = c + 1; m_tmo = 1'b0;
        m_pend = 3'b000; m_start = -100; m_valid = 1'b1;
      end else begin
        // Handshake window of a cold/warm sequence.
        if ((m_src == 1 || m_src == 2) && c >= m_wait && m_idle == INF) begin
          if (m_seen >= 0 && hs(c)) m_idle = c + 1 + P_HOLD;
          else begin
            if (!hs(c) && m_seen < 0) m_seen = c;
            if (c == m_wait + P_ACK - 1) begin
              m_tmo  = 1'b1;
              m_idle = c + 1 + P_HOLD;
            end
          end
        end
        rise = (c > 0) ? (req_h[c] & ~req_h[c-1]) : 3'b000;
        if (c >= m_idle) begin
          cand = rise | (PEND != 0 ? m_pend : 3'b000);
          pick = cand[0] ? 1 : cand[1] ? 2 : cand[2] ? 3 : 0;
          if (pick != 0) begin
            m_src = pick; m_last = pick; m_start = c;
            m_plen = (pick == 1) ? P_COLD : (pick == 2) ? P_WARM : P_DBG;
            if (pick == 3) m_idle = c + P_DBG + P_HOLD + 1;
            else begin
              m_wait = c + m_plen + 1; m_idle = INF; m_seen = -1;
            end
          end
          if (pick == 1) m_pend = 3'b000;
          else if (pick == 0) m_pend = cand;
          else m_pend = cand & ~(3'b001 << (pick - 1));
        end else begin
          m_pend = m_pend | rise;
        end
      end
      n      = c + 1;
      inp    = (n >= m_start + 1) && (n <= m_start + m_plen);
      e_cold = !(m_src == 1 && inp);
      e_warm = !(m_src == 2 && inp);
      e_dbg  = !(m_src == 3 && inp);
      e_busy = (n < m_idle);
      e_src  = 2'(m_last);
      e_tmo  = m_tmo;
    end
    cyc = c + 1;
  end

  task automatic chk_bit(input string nm, input int c, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %b want %b", nm, c, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid && cyc < NREC) begin
      rec[cyc] = {1'b0, e_tmo, e_busy, e_src, e_dbg, e_warm, e_cold,
                  1'b0, bus.ack_timeout, bus.busy, bus.last_src,
                  bus.debug_reset_req_n, bus.warm_reset_req_n, bus.cold_reset_req_n};
      chk_bit("cold_n",      cyc, bus.cold_reset_req_n,  e_cold);
      chk_bit("warm_n",      cyc, bus.warm_reset_req_n,  e_warm);
      chk_bit("debug_n",     cyc, bus.debug_reset_req_n, e_dbg);
      chk_bit("busy",        cyc, bus.busy,              e_busy);
      chk_bit("ack_timeout", cyc, bus.ack_timeout,       e_tmo);
      chk_bit("last_src0",   cyc, bus.last_src[0],       e_src[0]);
      chk_bit("last_src1",   cyc, bus.last_src[1],       e_src[1]);
    end
  end

  function automatic int find_val(input int b, input logic v, input int from, input int to);
    for (int k = from; k <= to && k < NREC; k++) if (rec[k][b] === v) return k;
    return -1;
  endfunction

  function automatic int run_len(input int b, input logic v, input int from);
    int r = 0;
    for (int k = from; k < NREC; k++) begin
      if (rec[k][b] !== v) break;
      r++;
    end
    return r;
  endfunction

  function automatic int count_val(input int b, input logic v, input int from, input int to);
    int r = 0;
    for (int k = from; k <= to && k < NREC; k++) if (rec[k][b] === v) r++;
    return r;
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t0, th, tw, tr;
    bus.reset_req   = 3'b000;
    bus.h2f_reset_n = 1'b1;
    rst             = 1'b1;
    ticks(3);
    // Reset state (cycle 1..3 are reset-driven values).
    check_int("reset_cold_n", int'(rec[2][0]), 1);
    check_int("reset_busy",   int'(rec[2][5]), 0);
    check_int("reset_src",    int'(rec[2][4:3]), 0);
    rst = 1'b0;
    ticks(5);

    // 1: cold edge, handshake, holdoff.
    t0 = cyc; bus.reset_req = 3'b001;
    ticks(8);
    bus.h2f_reset_n = 1'b0; ticks(10);
    th = cyc; bus.h2f_reset_n = 1'b1;
    ticks(P_HOLD + 10);
    check_int("t1_cold_first_low", find_val(0, 1'b0, t0, t0 + 20), t0 + 1);
    check_int("t1_cold_len",       run_len(0, 1'b0, t0 + 1), 6);
    check_int("t1_model_cold_len", run_len(8, 1'b0, t0 + 1), 6);
    check_int("t1_last_src",       int'(rec[t0+1][4:3]), 1);
    check_int("t1_busy_fall",      find_val(5, 1'b0, th, th + 100), th + 2 + P_HOLD + 1);

    // 2: warm+debug in one cycle.
    bus.reset_req = 3'b000; ticks(3);
    t0 = cyc; bus.reset_req = 3'b110;
    ticks(4);
    bus.h2f_reset_n = 1'b0; ticks(5);
    bus.h2f_reset_n = 1'b1; ticks(100);
    check_int("t2_warm_first_low", find_val(1, 1'b0, t0, t0 + 20), t0 + 1);
    check_int("t2_warm_len",       run_len(1, 1'b0, t0 + 1), 2);
    check_int("t2_cold_lows",      count_val(0, 1'b0, t0, cyc - 1), 0);
    check_int("t2_debug_lows",     count_val(2, 1'b0, t0, cyc - 1), PEND != 0 ? 32 : 0);

    // 3: debug edge, no handshake wait.
    bus.reset_req = 3'b000; ticks(3);
    t0 = cyc; bus.reset_req = 3'b100;
    ticks(70);
    check_int("t3_dbg_first_low", find_val(2, 1'b0, t0, t0 + 20), t0 + 1);
    check_int("t3_dbg_len",       run_len(2, 1'b0, t0 + 1), 32);
    check_int("t3_busy_len",      run_len(5, 1'b1, t0 + 1), P_DBG + P_HOLD);
    check_int("t3_model_busy",    run_len(13, 1'b1, t0 + 1), 52);
    check_int("t3_last_src",      int'(rec[t0+1][4:3]), 3);

    // 4: cold edge, h2f held high -> timeout.
    bus.reset_req = 3'b000; ticks(3);
    t0 = cyc; bus.reset_req = 3'b001;
    ticks(140);
    check_int("t4_tmo_rise", find_val(6, 1'b1, t0, cyc - 1), t0 + P_COLD + 1 + 100);
    check_int("t4_tmo_sticky", int'(rec[cyc-1][6]), 1);
    check_int("t4_idle_again", int'(rec[cyc-1][5]), 0);

    // 5: rst during cold pulse with request held.
    bus.reset_req = 3'b000; ticks(3);
    t0 = cyc; bus.reset_req = 3'b001;
    ticks(3);
    tr = cyc; rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    ticks(30);
    check_int("t5_pulse_active", int'(rec[tr][0]), 0);
    check_int("t5_cold_n_after", int'(rec[tr+1][0]), 1);
    check_int("t5_busy_after",   int'(rec[tr+1][5]), 0);
    check_int("t5_tmo_after",    int'(rec[tr+1][6]), 0);
    check_int("t5_no_pulse",     count_val(0, 1'b0, tr + 1, cyc - 1), 0);

    // 6: warm edge during holdoff.
    bus.reset_req = 3'b000; ticks(3);
    t0 = cyc; bus.reset_req = 3'b001;
    ticks(8);
    bus.h2f_reset_n = 1'b0; ticks(3);
    th = cyc; bus.h2f_reset_n = 1'b1;
    ticks(5);
    tw = cyc; bus.reset_req = 3'b011;
    ticks(60);
    check_int("t6_in_holdoff", int'(rec[tw][5]), 1);
    check_int("t6_warm_lows",  count_val(1, 1'b0, tw, tw + 59), PEND != 0 ? 2 : 0);

    // Random phase, checked by the model only.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 4) bus.reset_req = 3'($urandom);
      if (((i / 1000) % 2) == 0) begin
        if ($urandom_range(0, 99) < 10) bus.h2f_reset_n = ~bus.h2f_reset_n;
      end else if ($urandom_range(0, 99) < 1) begin
        bus.h2f_reset_n = ~bus.h2f_reset_n;
      end
      rst = ($urandom_range(0, 799) == 0);
    end
    rst = 1'b0;
    ticks(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
